// File: rtl/ventana_pkg.sv
// Shared geometry helpers for the sliding-window generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   DEF_*     default geometry (8-bit pixels, 5x5 window, 640x480 frame)
//   COL_W     column counter width for the default geometry
//   ROW_W     row counter width for the default geometry
//   cnt_w     counter width for any extent (never below 1 bit)
//   win_idx   bit offset of window pixel (r,c) in the flattened window bus
package ventana_pkg;

    localparam int DEF_BITS_PIXEL = 8;
    localparam int DEF_WIN        = 5;
    localparam int DEF_IMG_WIDTH  = 640;
    localparam int DEF_IMG_HEIGHT = 480;

    localparam int COL_W = $clog2(DEF_IMG_WIDTH);
    localparam int ROW_W = $clog2(DEF_IMG_HEIGHT);

    // A one-entry extent still needs a 1-bit counter.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Row 0 is the oldest line and column 0 the oldest pixel; row-major packing.
    function automatic int win_idx(input int r, input int c, input int win, input int bits);
        return (r * win + c) * bits;
    endfunction

endpackage

// File: rtl/buffer_linea_circular.sv
// Line store for the previous LANES image lines, one lane per line, shared column address.
// Latency: taps are combinational from addr_i; the write lands on the next rising edge.
// Backpressure: none internally; the owner only pulses wr_en_i on accepted pixels.
//
// Ports:
//   clk_i    clock
//   wr_en_i  accepted pixel: shift the column up one lane and insert din_i
//   addr_i   current column
//   din_i    incoming pixel, written into the newest lane
//   taps_o   lane j at [j*BITS_PIXEL +: BITS_PIXEL]; lane 0 is the oldest line
module buffer_linea_circular #(
    parameter int BITS_PIXEL = 8,
    parameter int LANES      = 4,
    parameter int DEPTH      = 640,
    parameter int ADDR_W     = 10
) (
    input  logic                          clk_i,
    input  logic                          wr_en_i,
    input  logic [ADDR_W-1:0]             addr_i,
    input  logic [BITS_PIXEL-1:0]         din_i,
    output logic [LANES*BITS_PIXEL-1:0]   taps_o
);

    // Not reset: the row counter keeps unwritten contents out of any valid window.
    logic [BITS_PIXEL-1:0] mem_q [LANES][DEPTH];

    // Read-before-write: taps show the column as it was before this beat's update.
    always_comb begin
        taps_o = '0;
        for (int j = 0; j < LANES; j++) begin
            taps_o[j*BITS_PIXEL +: BITS_PIXEL] = mem_q[j][addr_i];
        end
    end

    // Each accepted pixel ages its column by one line: every lane takes the
    // value of the next-newer lane and the newest lane takes the new pixel.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            for (int j = 0; j < LANES - 1; j++) begin
                mem_q[j][addr_i] <= mem_q[j+1][addr_i];
            end
            mem_q[LANES-1][addr_i] <= din_i;
        end
    end

endmodule

// File: rtl/ventana_pixeles_configurable.sv
// WIN x WIN sliding-window generator over a raster pixel stream.
// Latency: a window is presented one cycle after the pixel that completes it is accepted.
// Backpressure: in_ready = ~out_valid | out_ready; the window holds steady while stalled.
//
// Ports:
//   clk, reset             single clock, synchronous active-high reset
//   in_pixel/in_valid      raster-order pixel stream
//   in_sof                 restarts the frame at (0,0) with this beat's pixel
//   in_ready               pixel accepted when in_valid & in_ready
//   out_window             pixel (r,c) at [(r*WIN+c)*BITS_PIXEL +: BITS_PIXEL]
//   out_valid/out_ready    window handshake
//   out_eof                window ends at the last pixel of the frame
module ventana_pixeles_configurable
    import ventana_pkg::*;
#(
    parameter int BITS_PIXEL = DEF_BITS_PIXEL,
    parameter int WIN        = DEF_WIN,
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [BITS_PIXEL-1:0]         in_pixel,
    input  logic                          in_valid,
    input  logic                          in_sof,
    output logic                          in_ready,
    output logic [WIN*WIN*BITS_PIXEL-1:0] out_window,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_eof
);

    localparam int CW    = cnt_w(IMG_WIDTH);
    localparam int RW    = cnt_w(IMG_HEIGHT);
    localparam int LANES = WIN - 1;

    logic [CW-1:0] col_q, col_d, col_cur;
    logic [RW-1:0] row_q, row_d, row_cur;
    logic          out_valid_q, out_valid_d;
    logic          out_eof_q, out_eof_d;
    logic          acc;
    logic          win_ok;
    logic          last_pix;

    logic [BITS_PIXEL-1:0]       win_q [WIN][WIN];
    logic [BITS_PIXEL-1:0]       win_d [WIN][WIN];
    logic [LANES*BITS_PIXEL-1:0] taps;

    assign in_ready  = ~out_valid_q | out_ready;
    assign acc       = in_valid & in_ready;
    assign out_valid = out_valid_q;
    assign out_eof   = out_eof_q;

    // A start-of-frame beat is position (0,0) no matter where the counters were,
    // so the line-buffer address and the flags use this corrected position.
    assign col_cur = in_sof ? '0 : col_q;
    assign row_cur = in_sof ? '0 : row_q;

    assign win_ok   = (row_cur >= RW'(WIN - 1)) && (col_cur >= CW'(WIN - 1));
    assign last_pix = (row_cur == RW'(IMG_HEIGHT - 1)) && (col_cur == CW'(IMG_WIDTH - 1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (acc) begin
            if (col_cur == CW'(IMG_WIDTH - 1)) begin
                col_d = '0;
                row_d = (row_cur == RW'(IMG_HEIGHT - 1)) ? '0 : row_cur + RW'(1);
            end else begin
                col_d = col_cur + CW'(1);
                row_d = row_cur;
            end
        end
    end

    buffer_linea_circular #(
        .BITS_PIXEL (BITS_PIXEL),
        .LANES      (LANES),
        .DEPTH      (IMG_WIDTH),
        .ADDR_W     (CW)
    ) u_lineas (
        .clk_i   (clk),
        .wr_en_i (acc),
        .addr_i  (col_cur),
        .din_i   (in_pixel),
        .taps_o  (taps)
    );

    // Shift every row one column towards the oldest; the newest column is the
    // vertical slice of older lines plus the incoming pixel at the bottom.
    always_comb begin
        win_d = win_q;
        if (acc) begin
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
            end
            for (int r = 0; r < WIN - 1; r++) begin
                win_d[r][WIN-1] = taps[r*BITS_PIXEL +: BITS_PIXEL];
            end
            win_d[WIN-1][WIN-1] = in_pixel;
        end
    end

    // A new accept always replaces the flags: it can only happen once the
    // previous window has been taken (or there was none).
    always_comb begin
        out_valid_d = out_valid_q;
        out_eof_d   = out_eof_q;
        if (acc) begin
            out_valid_d = win_ok;
            out_eof_d   = win_ok & last_pix;
        end else if (out_valid_q & out_ready) begin
            out_valid_d = 1'b0;
            out_eof_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_eof_q   <= 1'b0;
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_eof_q   <= out_eof_d;
            win_q       <= win_d;
        end
    end

    always_comb begin
        out_window = '0;
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                out_window[win_idx(r, c, WIN, BITS_PIXEL) +: BITS_PIXEL] = win_q[r][c];
            end
        end
    end

endmodule

// File: tb/tb_ventana_pixeles_configurable.sv
// Directed-plus-random bench for the 3x3 window generator on a 4x4 frame.
// Latency: checks the one-cycle window latency against an image-array reference.
// Backpressure: drives random and forced out_ready stalls and random input gaps.
module tb_ventana_pixeles_configurable;

    localparam int BP  = 8;
    localparam int WIN = 3;
    localparam int W   = 4;
    localparam int H   = 4;
    localparam int WW  = WIN * WIN * BP;

    logic          clk = 1'b0;
    logic          reset;
    logic [BP-1:0] in_pixel;
    logic          in_valid;
    logic          in_sof;
    logic          in_ready;
    logic [WW-1:0] out_window;
    logic          out_valid;
    logic          out_ready;
    logic          out_eof;

    always #5 clk = ~clk;

    ventana_pixeles_configurable #(
        .BITS_PIXEL (BP),
        .WIN        (WIN),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_pixel   (in_pixel),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_ready   (in_ready),
        .out_window (out_window),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_eof    (out_eof)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: the frame as an image indexed by (row,col), plus the window
    // that should currently be on the output.
    logic [BP-1:0] img [H][W];
    int            mrow, mcol;
    logic          m_vld, m_eof;
    logic [WW-1:0] m_win;
    logic [BP-1:0] m_trig;

    // Observations gathered per test.
    int            n_win, n_eof;
    logic [WW-1:0] first_win, last_win;
    logic [BP-1:0] trig_log [$];

    bit gap_mode, rnd_ready, stall_req;
    int stall_left;

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs == exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mrow  = 0;
        mcol  = 0;
        m_vld = 1'b0;
        m_eof = 1'b0;
        m_win = '0;
    endtask

    task automatic clear_stats();
        n_win = 0;
        n_eof = 0;
        first_win = '0;
        last_win  = '0;
        trig_log.delete();
    endtask

    // One clock: called at the falling edge with inputs already applied.
    task automatic cycle(input logic rdy, output logic accepted);
        logic exp_rdy, pop;
        int r, c;
        out_ready = rdy;
        #1;
        exp_rdy = !m_vld || out_ready;
        chk_b("in_ready", in_ready, exp_rdy);
        chk_b("out_valid", out_valid, m_vld);
        if (m_vld) begin
            chk_w("out_window", out_window, m_win);
            chk_b("out_eof", out_eof, m_eof);
        end
        if (out_valid && out_ready) begin
            n_win++;
            if (n_win == 1) first_win = out_window;
            last_win = out_window;
            if (out_eof) n_eof++;
        end
        accepted = in_valid && exp_rdy;
        pop = m_vld && out_ready;
        if (pop) trig_log.push_back(m_trig);
        if (accepted) begin
            r = in_sof ? 0 : mrow;
            c = in_sof ? 0 : mcol;
            img[r][c] = in_pixel;
            m_vld = (r >= WIN - 1) && (c >= WIN - 1);
            m_eof = m_vld && (r == H - 1) && (c == W - 1);
            if (m_vld) begin
                m_win = '0;
                for (int i = 0; i < WIN; i++)
                    for (int j = 0; j < WIN; j++)
                        m_win[(i*WIN + j)*BP +: BP] = img[r-WIN+1+i][c-WIN+1+j];
                m_trig = in_pixel;
            end
            c++;
            if (c == W) begin
                c = 0;
                r = (r == H - 1) ? 0 : r + 1;
            end
            mrow = r;
            mcol = c;
        end else if (pop) begin
            m_vld = 1'b0;
            m_eof = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic pick_ready();
        return rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    endfunction

    task automatic send_pixel(input logic [BP-1:0] pix, input logic sof);
        logic a;
        logic rdy;
        int   tries;
        if (gap_mode && ($urandom_range(0, 3) == 0)) begin
            in_valid = 1'b0;
            in_sof   = 1'b0;
            cycle(pick_ready(), a);
        end
        in_valid = 1'b1;
        in_pixel = pix;
        in_sof   = sof;
        a = 1'b0;
        tries = 0;
        while (!a && tries < 60) begin
            if (stall_req && m_vld) begin
                stall_left = 5;
                stall_req  = 1'b0;
            end
            if (stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end else begin
                rdy = pick_ready();
            end
            cycle(rdy, a);
            tries++;
        end
        if (!a) begin
            n_cmp++;
            n_bad++;
            $error("FAIL accept_timeout: pixel %h not accepted within %0d cycles", pix, tries);
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic drain(input int n);
        logic a;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        for (int k = 0; k < n; k++) cycle(1'b1, a);
    endtask

    // Pixel (r,c) = off + r*16 + c, except (0,0) which may be overridden.
    task automatic send_frame(input logic sof_first, input int off, input int tl0);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send_pixel((r == 0 && c == 0) ? BP'(tl0) : BP'(off + r*16 + c),
                           sof_first && (r == 0) && (c == 0));
    endtask

    task automatic frame_checks(input string tag, input int off, input int tl0);
        logic [WW-1:0] exp_first;
        for (int i = 0; i < WIN; i++)
            for (int j = 0; j < WIN; j++)
                exp_first[(i*WIN + j)*BP +: BP] = (i == 0 && j == 0) ? BP'(tl0) : BP'(off + i*16 + j);
        chk_i({tag, "_nwin"}, n_win, 4);
        chk_i({tag, "_neof"}, n_eof, 1);
        chk_w({tag, "_first"}, first_win, exp_first);
        chk_w({tag, "_last_tl"}, WW'(last_win[BP-1:0]), WW'(off + 8'h11));
        chk_i({tag, "_ntrig"}, trig_log.size(), 4);
        if (trig_log.size() == 4) begin
            chk_w({tag, "_trig0"}, WW'(trig_log[0]), WW'(off + 8'h22));
            chk_w({tag, "_trig1"}, WW'(trig_log[1]), WW'(off + 8'h23));
            chk_w({tag, "_trig2"}, WW'(trig_log[2]), WW'(off + 8'h32));
            chk_w({tag, "_trig3"}, WW'(trig_log[3]), WW'(off + 8'h33));
        end
    endtask

    task automatic do_reset(input string tag);
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk_b({tag, "_out_valid"}, out_valid, 1'b0);
        chk_b({tag, "_out_eof"}, out_eof, 1'b0);
        chk_b({tag, "_in_ready"}, in_ready, 1'b1);
        chk_w({tag, "_out_window"}, out_window, '0);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_sof     = 1'b0;
        in_pixel   = '0;
        out_ready  = 1'b1;
        gap_mode   = 1'b0;
        rnd_ready  = 1'b0;
        stall_req  = 1'b0;
        stall_left = 0;
        model_reset();
        clear_stats();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state.
        do_reset("rst");

        // Test 1: clean frame, out_ready held high.
        clear_stats();
        send_frame(1'b1, 0, 8'h00);
        drain(3);
        frame_checks("t1", 0, 8'h00);

        // Test 2: same frame with a 5-cycle downstream stall on the first window.
        clear_stats();
        stall_req = 1'b1;
        send_frame(1'b1, 0, 8'h00);
        drain(3);
        frame_checks("t2", 0, 8'h00);

        // Test 3: input gaps and random out_ready; windows only after x2/x3 columns.
        clear_stats();
        gap_mode  = 1'b1;
        rnd_ready = 1'b1;
        send_frame(1'b1, 0, 8'h00);
        drain(3);
        frame_checks("t3", 0, 8'h00);
        gap_mode  = 1'b0;
        rnd_ready = 1'b0;

        // Test 4: part of a frame, then in_sof arrives on pixel 0x13.
        clear_stats();
        send_pixel(8'h00, 1'b1);
        send_pixel(8'h01, 1'b0);
        send_pixel(8'h02, 1'b0);
        send_pixel(8'h03, 1'b0);
        send_pixel(8'h10, 1'b0);
        send_pixel(8'h11, 1'b0);
        send_pixel(8'h12, 1'b0);
        send_frame(1'b1, 8'h80, 8'h13);
        drain(3);
        frame_checks("t4", 8'h80, 8'h13);

        // Test 5: reset while the 0x22 window is pending, then a full frame.
        clear_stats();
        send_frame_prefix();
        chk_b("t5_pending", out_valid, 1'b1);
        do_reset("t5_rst");
        clear_stats();
        send_frame(1'b1, 0, 8'h00);
        drain(3);
        frame_checks("t5", 0, 8'h00);

        // Test 6: two frames back to back, in_sof only on the first.
        clear_stats();
        gap_mode  = 1'b1;
        rnd_ready = 1'b1;
        send_frame(1'b1, 0, 8'h00);
        for (int k = 0; k < 2; k++) send_pixel($urandom_range(0, 255), 1'b0);
        for (int k = 2; k < W*H; k++) send_pixel(BP'((k / W) * 16 + (k % W)), 1'b0);
        drain(4);
        chk_i("t6_nwin", n_win, 8);
        chk_i("t6_neof", n_eof, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Rows 0..2 up to and including pixel 0x22.
    task automatic send_frame_prefix();
        for (int k = 0; k < 11; k++)
            send_pixel(BP'((k / W) * 16 + (k % W)), k == 0);
    endtask

endmodule
